// File: rtl/minimization_preimage_if.sv
// Stream/control bundle for the minimization preimage engine.
// The master side issues scan requests and consumes matches; the slave side is the engine.
interface minimization_preimage_if;
  logic       start;
  logic [1:0] code;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_value;
  logic       done;
  logic [3:0] count;

  modport master (
    output start, code, out_ready,
    input  busy, out_valid, out_value, done, count
  );

  modport slave (
    input  start, code, out_ready,
    output busy, out_valid, out_value, done, count
  );
endinterface

// File: rtl/minimization_preimage.sv
// Preimage engine for code = {~(i1^i0), ~i0}: enumerates every 4-bit value in 0..MAX_VAL mapping to a code.
// Optional MINIMIZATION_PREIMAGE_SKIP_EN solves the low bits from the code and strides by 4 instead of scanning.
module minimization_preimage #(
  parameter int MAX_VAL = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  minimization_preimage_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_C = 4'(MAX_VAL);
  localparam logic [4:0] MAX5   = 5'(MAX_VAL);

  function automatic logic [1:0] f_minimize(input logic [3:0] v);
    return {~(v[1] ^ v[0]), ~v[0]};
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_code;
  logic [1:0] w_code_nxt;
  logic [3:0] r_cand;
  logic [3:0] w_cand_nxt;
  logic       r_out_valid;
  logic       w_valid_nxt;
  logic [3:0] r_out_value;
  logic [3:0] w_value_nxt;
  logic [3:0] r_count;
  logic [3:0] w_count_nxt;
  logic       r_busy;
  logic       r_done;

  logic       w_match;
  logic       w_last;
  logic [3:0] w_cand_first;
  logic [3:0] w_cand_step;

`ifdef MINIMIZATION_PREIMAGE_SKIP_EN
  // Low two bits of any preimage are fully determined by the code.
  function automatic logic [3:0] f_residue(input logic [1:0] c);
    return {2'b00, c[1] ^ c[0], ~c[0]};
  endfunction

  // The end test looks ahead one stride so the candidate never has to wrap.
  assign w_match      = ({1'b0, r_cand} <= MAX5) && (f_minimize(r_cand) == r_code);
  assign w_last       = (({1'b0, r_cand} + 5'd4) > MAX5);
  assign w_cand_first = f_residue(bus.code);
  assign w_cand_step  = r_cand + 4'd4;
`else
  assign w_match      = (f_minimize(r_cand) == r_code);
  assign w_last       = (r_cand == LAST_C);
  assign w_cand_first = 4'd0;
  assign w_cand_step  = r_cand + 4'd1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath updates for the scan/emit sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cand_nxt  = r_cand;
    w_valid_nxt = r_out_valid;
    w_value_nxt = r_out_value;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_code_nxt  = bus.code;
          w_cand_nxt  = w_cand_first;
          w_count_nxt = 4'd0;
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_match) begin
          w_value_nxt = r_cand;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_EMIT;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cand_nxt  = w_cand_step;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_EMIT: begin
        if (r_out_valid && bus.out_ready) begin
          w_valid_nxt = 1'b0;
          w_count_nxt = r_count + 4'd1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cand_nxt  = w_cand_step;
            w_state_nxt = ST_SCAN;
          end
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and status registers; busy/done track the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code      <= 2'd0;
      r_cand      <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_value <= 4'd0;
      r_count     <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_code      <= w_code_nxt;
      r_cand      <= w_cand_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_value <= w_value_nxt;
      r_count     <= w_count_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_value = r_out_value;
  assign bus.done      = r_done;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_minimization_preimage.sv
// Scoreboard bench for minimization_preimage: three instances (MAX_VAL 9, 15, 0) sharing clock and reset.
// Expected preimages are computed from the code formula and queued before each scan.
module tb_minimization_preimage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r_start = 1'b0;
  logic [1:0] r_code_in = 2'b00;
  logic       r_ready = 1'b1;
  int         sel = 0;
  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_q[$];

  logic       m_busy, m_valid, m_done;
  logic [3:0] m_value, m_count;

  minimization_preimage_if ifa ();
  minimization_preimage_if ifb ();
  minimization_preimage_if ifc ();

  assign ifa.start = r_start && (sel == 0);
  assign ifb.start = r_start && (sel == 1);
  assign ifc.start = r_start && (sel == 2);
  assign ifa.code = r_code_in;
  assign ifb.code = r_code_in;
  assign ifc.code = r_code_in;
  assign ifa.out_ready = r_ready;
  assign ifb.out_ready = r_ready;
  assign ifc.out_ready = r_ready;

  minimization_preimage #(.MAX_VAL(9))  u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  minimization_preimage #(.MAX_VAL(15)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  minimization_preimage #(.MAX_VAL(0))  u_dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;

  always_comb begin
    m_busy = ifa.busy; m_valid = ifa.out_valid; m_value = ifa.out_value;
    m_done = ifa.done; m_count = ifa.count;
    case (sel)
      1: begin
        m_busy = ifb.busy; m_valid = ifb.out_valid; m_value = ifb.out_value;
        m_done = ifb.done; m_count = ifb.count;
      end
      2: begin
        m_busy = ifc.busy; m_valid = ifc.out_valid; m_value = ifc.out_value;
        m_done = ifc.done; m_count = ifc.count;
      end
      default: ;
    endcase
  end

  function automatic int max_of(input int s);
    return (s == 1) ? 15 : ((s == 2) ? 0 : 9);
  endfunction

  function automatic int exp_lat(input int mx, input int nm);
`ifdef MINIMIZATION_PREIMAGE_SKIP_EN
    return 2 * nm + 1;
`else
    return (mx + 1) + nm + 1;
`endif
  endfunction

  // Starts a scan, pops/compares every accepted value; returns done latency and expected match count.
  task automatic run_scan(input int s, input logic [1:0] c, input int stall, input int inject_at,
                          output int lat, output int nm);
    int cyc;
    int stall_cnt;
    logic [3:0] held;
    logic [3:0] e;
    logic [3:0] vv;
    exp_q.delete();
    nm = 0;
    for (int v = 0; v <= max_of(s); v++) begin
      vv = 4'(v);
      if ({~(vv[1] ^ vv[0]), ~vv[0]} == c) begin
        exp_q.push_back(vv);
        nm++;
      end
    end
    sel = s; r_code_in = c; r_ready = (stall == 0); r_start = 1'b1;
    cyc = 0; lat = -1; stall_cnt = 0; held = 4'd0;
    while (lat < 0 && cyc < 400) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      r_start = 1'b0; r_code_in = c;
      if (cyc == inject_at) begin
        r_start = 1'b1; r_code_in = 2'b01;
      end
      if (m_done) begin
        lat = cyc;
      end else if (m_valid) begin
        if (stall_cnt < stall) begin
          if (stall_cnt > 0) begin
            total++;
            if (m_value !== held || m_count !== 4'd0) begin
              bad++;
              $display("FAIL hold value=%0d count=%0d required value=%0d count=0", m_value, m_count, held);
            end
          end
          held = m_value; stall_cnt++; r_ready = 1'b0;
        end else begin
          r_ready = 1'b1;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_value got=%0d required=none", m_value);
          end else begin
            e = exp_q.pop_front();
            if (m_value !== e) begin
              bad++;
              $display("FAIL value got=%0d required=%0d", m_value, e);
            end
          end
        end
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout no done within %0d cycles", cyc);
    end
    r_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (ifa.busy !== 1'b0 || ifa.out_valid !== 1'b0 || ifa.done !== 1'b0) begin
      bad++; $display("FAIL reset_flags busy=%b valid=%b done=%b required 0", ifa.busy, ifa.out_valid, ifa.done);
    end
    total++;
    if (ifa.out_value !== 4'd0 || ifa.count !== 4'd0) begin
      bad++; $display("FAIL reset_data value=%0d count=%0d required 0", ifa.out_value, ifa.count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan(input string name, input int s, input logic [1:0] c, input int stall,
                           input int exp_count, input logic chk_lat);
    int lat, nm;
    run_scan(s, c, stall, -1, lat, nm);
    total++;
    if (m_count !== 4'(exp_count) || nm != exp_count) begin
      bad++; $display("FAIL %s count got=%0d required=%0d", name, m_count, exp_count);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL %s missing %0d values", name, exp_q.size());
    end
    if (chk_lat) begin
      total++;
      if (lat != exp_lat(max_of(s), nm)) begin
        bad++; $display("FAIL %s latency got=%0d required=%0d", name, lat, exp_lat(max_of(s), nm));
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (m_done !== 1'b0 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
        bad++; $display("FAIL %s after_done done=%b busy=%b valid=%b required 0", name, m_done, m_busy, m_valid);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, nm;
    run_scan(0, 2'b11, 0, 3, lat, nm);
    total++;
    if (m_count !== 4'd3 || exp_q.size() != 0) begin
      bad++; $display("FAIL busy_start count got=%0d required=3 left=%0d", m_count, exp_q.size());
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_done_start();
    int lat, nm;
    run_scan(0, 2'b10, 0, -1, lat, nm);
    r_start = 1'b1; r_code_in = 2'b11;
    @(posedge clk); @(negedge clk);
    r_start = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if (m_busy !== 1'b0 || m_count !== 4'd2) begin
      bad++; $display("FAIL done_start busy=%b count=%0d required busy=0 count=2", m_busy, m_count);
    end
  endtask

  task automatic test_reset_mid_emit();
    int cyc;
    logic found;
    sel = 0; r_code_in = 2'b11; r_ready = 1'b1; r_start = 1'b1;
    cyc = 0; found = 1'b0;
    while (!found && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      r_start = 1'b0;
      if (m_valid && m_value == 4'd4) begin
        r_ready = 1'b0; found = 1'b1;
      end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL mid_emit value 4 never emitted");
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_value !== 4'd0 || m_count !== 4'd0 || m_done !== 1'b0) begin
      bad++; $display("FAIL mid_emit_reset busy=%b valid=%b value=%0d count=%0d required all 0",
                      m_busy, m_valid, m_value, m_count);
    end
    @(negedge clk);
    rst_n = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    test_scan("after_reset", 0, 2'b11, 0, 3, 1'b1);
  endtask

  initial begin
    test_reset();
    test_scan("code11", 0, 2'b11, 0, 3, 1'b1);
    test_scan("code10", 0, 2'b10, 0, 2, 1'b1);
    test_scan("backpressure", 0, 2'b00, 5, 3, 1'b0);
    test_start_while_busy();
    test_done_start();
    test_reset_mid_emit();
    test_scan("max15", 1, 2'b00, 0, 4, 1'b1);
    test_scan("empty", 2, 2'b00, 0, 0, 1'b0);
    test_scan("code01", 0, 2'b01, 0, 2, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
